// File: rtl/dpram64_bridge_if.sv
// dpram64_bridge_if -- request/response handshake bundle for dpram64_bridge.
//   Request : i_req_valid/o_req_ready, i_req_we, i_req_addr[AW], i_req_wdata[32], i_req_be[4]
//   Response: o_rsp_valid/i_rsp_ready, o_rsp_rdata[32], o_rsp_we
//   slave  modport: bridge side.  master modport: requester side.
interface dpram64_bridge_if #(
    parameter int SIZE = 65536
);
    localparam int AW = $clog2(SIZE);

    logic          i_req_valid;
    logic          o_req_ready;
    logic          i_req_we;
    logic [AW-1:0] i_req_addr;
    logic [31:0]   i_req_wdata;
    logic [3:0]    i_req_be;
    logic          o_rsp_valid;
    logic          i_rsp_ready;
    logic [31:0]   o_rsp_rdata;
    logic          o_rsp_we;

    modport slave (
        input  i_req_valid, i_req_we, i_req_addr, i_req_wdata, i_req_be, i_rsp_ready,
        output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_we
    );

    modport master (
        output i_req_valid, i_req_we, i_req_addr, i_req_wdata, i_req_be, i_rsp_ready,
        input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_we
    );
endinterface

// File: rtl/dpram64_bridge.sv
// dpram64_bridge -- 32-bit valid/ready request port onto a 64-bit dual-port RAM
// with one-cycle registered read latency.
//   clk, rst        : clock, synchronous active-high reset
//   bus (slave)     : request/response handshake (see dpram64_bridge_if)
//   o_ram_we[8]     : RAM byte write enables
//   o_ram_din[64]   : RAM write data (word replicated into both halves)
//   o_ram_waddr/raddr[AW] : RAM byte addresses (straight from the request)
//   i_ram_dout[64]  : RAM read data, valid the cycle after raddr
//   o_rd_count/o_wr_count[32] : accepted read/write counters, only when
//                     DPRAM64_BRIDGE_STATS_EN is defined
// A request sits in P1 for one cycle while the RAM reads, then lands in a
// 2-entry response FIFO. An empty FIFO is bypassed so P1 can answer directly.
module dpram64_bridge #(
    parameter  int SIZE = 65536,
    localparam int AW   = $clog2(SIZE)
) (
    input  logic          clk,
    input  logic          rst,
    dpram64_bridge_if.slave bus,
    output logic [7:0]    o_ram_we,
    output logic [63:0]   o_ram_din,
    output logic [AW-1:0] o_ram_waddr,
    output logic [AW-1:0] o_ram_raddr,
    input  logic [63:0]   i_ram_dout
`ifdef DPRAM64_BRIDGE_STATS_EN
    ,
    output logic [31:0]   o_rd_count,
    output logic [31:0]   o_wr_count
`endif
);

    // P1 stage: remembers kind of request and which RAM half to pick
    logic p1_vld_q, p1_we_q, p1_hi_q;

    // response FIFO
    logic [1:0][31:0] f_data_q;
    logic [1:0]       f_we_q;
    logic             wp_q, rp_q;
    logic [1:0]       cnt_q, cnt_d;

    logic [1:0]  occ;
    logic        fifo_empty, fire, pop, push, fpop;
    logic [31:0] p1_rdata;
    logic [7:0]  be_sh;

    assign fifo_empty = (cnt_q == 2'd0);
    assign occ        = cnt_q + {1'b0, p1_vld_q};

    // P1 answer comes straight off the RAM output; writes answer with 0
    assign p1_rdata = p1_we_q ? 32'h0 : (p1_hi_q ? i_ram_dout[63:32] : i_ram_dout[31:0]);

    assign bus.o_rsp_valid = !fifo_empty || p1_vld_q;
    assign bus.o_rsp_rdata = !fifo_empty ? f_data_q[rp_q] : (p1_vld_q ? p1_rdata : 32'h0);
    assign bus.o_rsp_we    = !fifo_empty ? f_we_q[rp_q]   : (p1_vld_q && p1_we_q);

    assign pop  = bus.o_rsp_valid && bus.i_rsp_ready;
    // a pop frees a slot this same cycle, so a full bridge still accepts
    assign bus.o_req_ready = !rst && ((occ < 2'd2) || pop);
    assign fire = bus.i_req_valid && bus.o_req_ready;

    // P1 moves into the FIFO unless it was consumed through the bypass
    assign push = p1_vld_q && !(fifo_empty && pop);
    assign fpop = pop && !fifo_empty;

    always_comb begin
        cnt_d = cnt_q;
        if (push && !fpop)      cnt_d = cnt_q + 2'd1;
        else if (!push && fpop) cnt_d = cnt_q - 2'd1;
    end

    // RAM side is purely combinational from the accepted request
    assign be_sh       = bus.i_req_addr[2] ? {bus.i_req_be, 4'h0} : {4'h0, bus.i_req_be};
    assign o_ram_we    = (fire && bus.i_req_we) ? be_sh : 8'h00;
    assign o_ram_din   = {bus.i_req_wdata, bus.i_req_wdata};
    assign o_ram_waddr = bus.i_req_addr;
    assign o_ram_raddr = bus.i_req_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            p1_vld_q <= 1'b0;
            p1_we_q  <= 1'b0;
            p1_hi_q  <= 1'b0;
            f_data_q <= '0;
            f_we_q   <= '0;
            wp_q     <= 1'b0;
            rp_q     <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            p1_vld_q <= fire;
            if (fire) begin
                p1_we_q <= bus.i_req_we;
                p1_hi_q <= bus.i_req_addr[2];
            end
            if (push) begin
                f_data_q[wp_q] <= p1_rdata;
                f_we_q[wp_q]   <= p1_we_q;
                wp_q           <= ~wp_q;
            end
            if (fpop) rp_q <= ~rp_q;
            cnt_q <= cnt_d;
        end
    end

`ifdef DPRAM64_BRIDGE_STATS_EN
    logic [31:0] rd_cnt_q, wr_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt_q <= 32'h0;
            wr_cnt_q <= 32'h0;
        end else if (fire) begin
            if (bus.i_req_we) wr_cnt_q <= wr_cnt_q + 32'h1;
            else              rd_cnt_q <= rd_cnt_q + 32'h1;
        end
    end

    assign o_rd_count = rd_cnt_q;
    assign o_wr_count = wr_cnt_q;
`endif

endmodule

// File: tb/tb_dpram64_bridge.sv
module tb_dpram64_bridge;
    localparam int SIZE = 65536;
    localparam int AW   = $clog2(SIZE);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    ram_we;
    logic [63:0]   ram_din;
    logic [AW-1:0] ram_waddr, ram_raddr;
    logic [63:0]   ram_dout;
    logic          mem_clr = 1'b1;
    logic [63:0]   mem [16];
    int n_cmp = 0;
    int n_err = 0;
`ifdef DPRAM64_BRIDGE_STATS_EN
    logic [31:0] rd_count, wr_count;
`endif

    dpram64_bridge_if #(.SIZE(SIZE)) bus ();

    dpram64_bridge #(.SIZE(SIZE)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .o_ram_we(ram_we), .o_ram_din(ram_din),
        .o_ram_waddr(ram_waddr), .o_ram_raddr(ram_raddr),
        .i_ram_dout(ram_dout)
`ifdef DPRAM64_BRIDGE_STATS_EN
        , .o_rd_count(rd_count), .o_wr_count(wr_count)
`endif
    );

    always #5 clk = ~clk;

    // small RAM model: 16 x 64-bit words, registered read
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int w = 0; w < 16; w++) mem[w] <= 64'h0;
            ram_dout <= 64'h0;
        end else begin
            for (int b = 0; b < 8; b++)
                if (ram_we[b]) mem[ram_waddr[6:3]][8*b +: 8] <= ram_din[8*b +: 8];
            ram_dout <= mem[ram_raddr[6:3]];
        end
    end

    task automatic drive(input logic v, input logic we, input logic [AW-1:0] a,
                         input logic [31:0] wd, input logic [3:0] be);
        bus.i_req_valid = v;
        bus.i_req_we    = we;
        bus.i_req_addr  = a;
        bus.i_req_wdata = wd;
        bus.i_req_be    = be;
    endtask

    task automatic test_reset;
        rst = 1'b1; mem_clr = 1'b1;
        bus.i_rsp_ready = 1'b1;
        drive(1'b1, 1'b1, 16'h0, 32'h12345678, 4'hF);
        @(negedge clk); @(negedge clk); #1;
        n_cmp++; if (bus.o_req_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready_low got=%0h exp=0", bus.o_req_ready); end
        n_cmp++; if (ram_we !== 8'h00) begin n_err++; $display("FAIL rst_ram_we got=%0h exp=00", ram_we); end
        @(negedge clk);
        drive(1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
        rst = 1'b0; mem_clr = 1'b0;
        @(negedge clk); #1;
        n_cmp++; if (bus.o_req_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready_after got=%0h exp=1", bus.o_req_ready); end
        n_cmp++; if (bus.o_rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_rsp_valid got=%0h exp=0", bus.o_rsp_valid); end
        n_cmp++; if (bus.o_rsp_rdata !== 32'h0) begin n_err++; $display("FAIL rst_rsp_rdata got=%0h exp=0", bus.o_rsp_rdata); end
        n_cmp++; if (bus.o_rsp_we !== 1'b0) begin n_err++; $display("FAIL rst_rsp_we got=%0h exp=0", bus.o_rsp_we); end
    endtask

    task automatic test_write;
        @(negedge clk);
        drive(1'b1, 1'b1, 16'h0014, 32'hDEADBEEF, 4'hF); #1;
        n_cmp++; if (bus.o_req_ready !== 1'b1) begin n_err++; $display("FAIL wr_ready got=%0h exp=1", bus.o_req_ready); end
        n_cmp++; if (ram_we !== 8'hF0) begin n_err++; $display("FAIL wr_ram_we got=%0h exp=f0", ram_we); end
        n_cmp++; if (ram_din !== 64'hDEADBEEF_DEADBEEF) begin n_err++; $display("FAIL wr_ram_din got=%0h exp=deadbeefdeadbeef", ram_din); end
        n_cmp++; if (ram_waddr !== 16'h0014) begin n_err++; $display("FAIL wr_waddr got=%0h exp=14", ram_waddr); end
        @(negedge clk);
        drive(1'b0, 1'b0, 16'h0, 32'h0, 4'h0); #1;
        n_cmp++; if ({bus.o_rsp_valid, bus.o_rsp_we} !== 2'b11) begin n_err++; $display("FAIL wr_rsp_vld_we got=%0b exp=11", {bus.o_rsp_valid, bus.o_rsp_we}); end
        n_cmp++; if (bus.o_rsp_rdata !== 32'h0) begin n_err++; $display("FAIL wr_rsp_rdata got=%0h exp=0", bus.o_rsp_rdata); end
        @(negedge clk); #1;
        n_cmp++; if (bus.o_rsp_valid !== 1'b0) begin n_err++; $display("FAIL wr_rsp_drained got=%0h exp=0", bus.o_rsp_valid); end
    endtask

    task automatic test_read;
        @(negedge clk);
        drive(1'b1, 1'b0, 16'h0014, 32'h0, 4'hF); #1;
        n_cmp++; if (ram_raddr !== 16'h0014) begin n_err++; $display("FAIL rd_raddr got=%0h exp=14", ram_raddr); end
        n_cmp++; if (ram_we !== 8'h00) begin n_err++; $display("FAIL rd_ram_we got=%0h exp=00", ram_we); end
        @(negedge clk);
        drive(1'b1, 1'b0, 16'h0010, 32'h0, 4'h0); #1;
        n_cmp++; if (bus.o_rsp_valid !== 1'b1 || bus.o_rsp_we !== 1'b0) begin n_err++; $display("FAIL rd_hi_vld_we got=%0b%0b exp=10", bus.o_rsp_valid, bus.o_rsp_we); end
        n_cmp++; if (bus.o_rsp_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL rd_hi_rdata got=%0h exp=deadbeef", bus.o_rsp_rdata); end
        @(negedge clk);
        drive(1'b0, 1'b0, 16'h0, 32'h0, 4'h0); #1;
        n_cmp++; if (bus.o_rsp_valid !== 1'b1 || bus.o_rsp_rdata !== 32'h0) begin n_err++; $display("FAIL rd_lo_rdata got=%0b/%0h exp=1/0", bus.o_rsp_valid, bus.o_rsp_rdata); end
    endtask

    task automatic test_raw_be0;
        @(negedge clk);
        drive(1'b1, 1'b1, 16'h0010, 32'h11223344, 4'b0101); #1;
        n_cmp++; if (ram_we !== 8'h05) begin n_err++; $display("FAIL be_partial_we got=%0h exp=05", ram_we); end
        @(negedge clk);
        drive(1'b1, 1'b0, 16'h0010, 32'h0, 4'h0); #1;
        n_cmp++; if ({bus.o_rsp_valid, bus.o_rsp_we} !== 2'b11) begin n_err++; $display("FAIL raw_wr_rsp got=%0b exp=11", {bus.o_rsp_valid, bus.o_rsp_we}); end
        @(negedge clk);
        drive(1'b1, 1'b1, 16'h0010, 32'hFFFFFFFF, 4'h0); #1;
        n_cmp++; if (ram_we !== 8'h00 || bus.o_req_ready !== 1'b1) begin n_err++; $display("FAIL be0_accept got=%0h/%0b exp=00/1", ram_we, bus.o_req_ready); end
        n_cmp++; if (bus.o_rsp_rdata !== 32'h00220044 || bus.o_rsp_we !== 1'b0) begin n_err++; $display("FAIL raw_rdata got=%0h exp=00220044", bus.o_rsp_rdata); end
        @(negedge clk);
        drive(1'b1, 1'b0, 16'h0010, 32'h0, 4'h0); #1;
        n_cmp++; if ({bus.o_rsp_valid, bus.o_rsp_we} !== 2'b11) begin n_err++; $display("FAIL be0_rsp got=%0b exp=11", {bus.o_rsp_valid, bus.o_rsp_we}); end
        @(negedge clk);
        drive(1'b0, 1'b0, 16'h0, 32'h0, 4'h0); #1;
        n_cmp++; if (bus.o_rsp_rdata !== 32'h00220044) begin n_err++; $display("FAIL be0_unchanged got=%0h exp=00220044", bus.o_rsp_rdata); end
    endtask

    task automatic test_back_to_back;
        for (int ph = 0; ph < 2; ph++) begin
            for (int i = 0; i <= 8; i++) begin
                @(negedge clk);
                if (i < 8) drive(1'b1, (ph == 0), 16'(4*i), 32'hA0000000 + 32'(i), 4'hF);
                else       drive(1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
                #1;
                if (i < 8) begin
                    n_cmp++; if (bus.o_req_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready ph=%0d i=%0d got=0 exp=1", ph, i); end
                end
                if (i > 0) begin
                    n_cmp++;
                    if (bus.o_rsp_valid !== 1'b1 || bus.o_rsp_we !== (ph == 0) ||
                        bus.o_rsp_rdata !== ((ph == 0) ? 32'h0 : 32'hA0000000 + 32'(i-1))) begin
                        n_err++;
                        $display("FAIL b2b_rsp ph=%0d i=%0d got=%0b/%0b/%0h", ph, i, bus.o_rsp_valid, bus.o_rsp_we, bus.o_rsp_rdata);
                    end
                end
            end
        end
        @(negedge clk); #1;
        n_cmp++; if (bus.o_rsp_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drained got=%0h exp=0", bus.o_rsp_valid); end
    endtask

    task automatic test_backpressure;
        logic        exp_rdy [7];
        logic        exp_vld [7];
        logic [31:0] exp_dat [7];
        exp_rdy = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        exp_vld = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        exp_dat = '{32'h0, 32'hA0000000, 32'hA0000000, 32'hA0000000,
                    32'hA0000000, 32'hA0000001, 32'hA0000002};
        bus.i_rsp_ready = 1'b0;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            if (c == 4) bus.i_rsp_ready = 1'b1;
            if (c < 3)      drive(1'b1, 1'b0, 16'(4*c), 32'h0, 4'h0);
            else if (c < 5) drive(1'b1, 1'b0, 16'h0008, 32'h0, 4'h0);
            else            drive(1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
            #1;
            if (c < 5) begin
                n_cmp++; if (bus.o_req_ready !== exp_rdy[c]) begin n_err++; $display("FAIL bp_ready c=%0d got=%0b exp=%0b", c, bus.o_req_ready, exp_rdy[c]); end
            end
            n_cmp++;
            if (bus.o_rsp_valid !== exp_vld[c] || (exp_vld[c] && bus.o_rsp_rdata !== exp_dat[c])) begin
                n_err++;
                $display("FAIL bp_rsp c=%0d got=%0b/%0h exp=%0b/%0h", c, bus.o_rsp_valid, bus.o_rsp_rdata, exp_vld[c], exp_dat[c]);
            end
        end
        @(negedge clk); #1;
        n_cmp++; if (bus.o_rsp_valid !== 1'b0) begin n_err++; $display("FAIL bp_drained got=%0h exp=0", bus.o_rsp_valid); end
    endtask

    task automatic test_reset_flush;
        bus.i_rsp_ready = 1'b0;
        @(negedge clk); drive(1'b1, 1'b0, 16'h0000, 32'h0, 4'h0);
        @(negedge clk); drive(1'b1, 1'b0, 16'h0004, 32'h0, 4'h0);
        @(negedge clk); drive(1'b0, 1'b0, 16'h0, 32'h0, 4'h0); #1;
        n_cmp++; if (bus.o_req_ready !== 1'b0 || bus.o_rsp_valid !== 1'b1) begin n_err++; $display("FAIL flush_full got=%0b/%0b exp=0/1", bus.o_req_ready, bus.o_rsp_valid); end
        rst = 1'b1;
        @(negedge clk); #1;
        n_cmp++; if (bus.o_rsp_valid !== 1'b0) begin n_err++; $display("FAIL flush_rsp_valid got=%0h exp=0", bus.o_rsp_valid); end
        rst = 1'b0;
        bus.i_rsp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            n_cmp++; if (bus.o_rsp_valid !== 1'b0) begin n_err++; $display("FAIL flush_stale k=%0d got=%0h exp=0", k, bus.o_rsp_valid); end
        end
        @(negedge clk); drive(1'b1, 1'b0, 16'h0004, 32'h0, 4'h0);
        @(negedge clk); drive(1'b0, 1'b0, 16'h0, 32'h0, 4'h0); #1;
        n_cmp++; if (bus.o_rsp_valid !== 1'b1 || bus.o_rsp_rdata !== 32'hA0000001) begin n_err++; $display("FAIL flush_resume got=%0b/%0h exp=1/a0000001", bus.o_rsp_valid, bus.o_rsp_rdata); end
    endtask

`ifdef DPRAM64_BRIDGE_STATS_EN
    task automatic test_stats;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0; #1;
        n_cmp++; if (rd_count !== 32'h0 || wr_count !== 32'h0) begin n_err++; $display("FAIL stats_reset got=%0d/%0d exp=0/0", rd_count, wr_count); end
        bus.i_rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive(1'b1, (i < 5), 16'(4*i), 32'h0, 4'hF);
        end
        @(negedge clk); drive(1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
        @(negedge clk); #1;
        n_cmp++; if (wr_count !== 32'd5) begin n_err++; $display("FAIL stats_wr got=%0d exp=5", wr_count); end
        n_cmp++; if (rd_count !== 32'd3) begin n_err++; $display("FAIL stats_rd got=%0d exp=3", rd_count); end
    endtask
`endif

    initial begin
        drive(1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
        bus.i_rsp_ready = 1'b1;
        test_reset();
        test_write();
        test_read();
        test_raw_be0();
        test_back_to_back();
        test_backpressure();
        test_reset_flush();
`ifdef DPRAM64_BRIDGE_STATS_EN
        test_stats();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
